// File: rtl/ts_mem_loader.sv
// Timestamp table loader: streams accepted entries into ping-pong frame tables
// and flags the shadow bank as loaded once every frame table has been written.
module ts_mem_loader (
   input  logic        clk_i,
   input  logic        nrst_i,
   input  logic        enable_i,
   input  logic        s_valid_i,
   input  logic [16:0] s_data_i,
   output logic        s_ready_o,
   input  logic        update_mem_i,
   input  logic [10:0] entries_per_frame_i,
   input  logic [2:0]  number_of_frames_i,
   output logic [10:0] waddr_o,
   output logic [16:0] wdata_o,
   output logic        wen_o,
   output logic [2:0]  memory_selector_o,
   output logic        mem_updated_o,
   output logic        abort_o
);

   typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

   state_e      state_q, state_d;
   logic [10:0] addr_q, addr_d;
   logic [2:0]  frame_q, frame_d;
   logic [10:0] entries_q, entries_d;
   logic [2:0]  last_q, last_d;
   logic        upd_q, upd_seen_q;
   logic        abort_q, abort_d;
   logic        wen_q;
   logic [10:0] waddr_q;
   logic [16:0] wdata_q;
   logic [2:0]  sel_q;
   logic        toggle, accept, start;
   logic [2:0]  nf_clamped;

   // upd_seen_q masks the first cycle after reset so upd_q can load the live
   // bank select without reporting a spurious toggle.
   assign toggle     = upd_seen_q & (update_mem_i ^ upd_q);
   assign nf_clamped = (number_of_frames_i > 3'd4) ? 3'd4 : number_of_frames_i;
   assign s_ready_o  = (state_q == StLoad) && !toggle && (entries_q != 11'd0);
   assign accept     = s_valid_i & s_ready_o;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      frame_d   = frame_q;
      entries_d = entries_q;
      last_d    = last_q;
      abort_d   = 1'b0;
      start     = 1'b0;
      if (!enable_i) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: start = 1'b1;
            StLoad: begin
               if (toggle) begin
                  start   = 1'b1;
                  abort_d = 1'b1;
               end else if (entries_q == 11'd0) begin
                  state_d = StDone;
               end else if (accept) begin
                  if (addr_q == entries_q - 11'd1) begin
                     addr_d = 11'd0;
                     if (frame_q == last_q) state_d = StDone;
                     else                   frame_d = frame_q + 3'd1;
                  end else begin
                     addr_d = addr_q + 11'd1;
                  end
               end
            end
            StDone: start = toggle;
            default: state_d = StIdle;
         endcase
      end
      // Every entry into LOAD snapshots the configuration and rewinds the counters.
      if (start) begin
         state_d   = StLoad;
         addr_d    = 11'd0;
         frame_d   = 3'd0;
         entries_d = entries_per_frame_i;
         last_d    = nf_clamped;
      end
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state_q    <= StIdle;
         addr_q     <= 11'd0;
         frame_q    <= 3'd0;
         entries_q  <= 11'd0;
         last_q     <= 3'd0;
         upd_q      <= 1'b0;
         upd_seen_q <= 1'b0;
         abort_q    <= 1'b0;
         wen_q      <= 1'b0;
         waddr_q    <= 11'd0;
         wdata_q    <= 17'd0;
         sel_q      <= 3'd0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         frame_q    <= frame_d;
         entries_q  <= entries_d;
         last_q     <= last_d;
         upd_q      <= update_mem_i;
         upd_seen_q <= 1'b1;
         abort_q    <= abort_d;
         wen_q      <= accept;
         if (accept) begin
            waddr_q <= addr_q;
            wdata_q <= s_data_i;
            sel_q   <= frame_q;
         end
      end
   end

   assign waddr_o           = waddr_q;
   assign wdata_o           = wdata_q;
   assign wen_o             = wen_q;
   assign memory_selector_o = sel_q;
   assign mem_updated_o     = (state_q == StDone);
   assign abort_o           = abort_q;

endmodule

// File: tb/tb_ts_mem_loader.sv
// Directed bench for ts_mem_loader: a reference model pushes expected table writes
// on each handshake and the monitor pops and compares them against the write port.
module tb_ts_mem_loader;

   logic        clk_i = 1'b0;
   logic        nrst_i, enable_i, s_valid_i, s_ready_o, update_mem_i;
   logic [16:0] s_data_i;
   logic [10:0] entries_per_frame_i, waddr_o;
   logic [2:0]  number_of_frames_i, memory_selector_o;
   logic [16:0] wdata_o;
   logic        wen_o, mem_updated_o, abort_o;

   ts_mem_loader dut (
      .clk_i               (clk_i),
      .nrst_i              (nrst_i),
      .enable_i            (enable_i),
      .s_valid_i           (s_valid_i),
      .s_data_i            (s_data_i),
      .s_ready_o           (s_ready_o),
      .update_mem_i        (update_mem_i),
      .entries_per_frame_i (entries_per_frame_i),
      .number_of_frames_i  (number_of_frames_i),
      .waddr_o             (waddr_o),
      .wdata_o             (wdata_o),
      .wen_o               (wen_o),
      .memory_selector_o   (memory_selector_o),
      .mem_updated_o       (mem_updated_o),
      .abort_o             (abort_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int sel;
      int addr;
      int data;
      bit fin;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0, n_err = 0;
   int   nacc = 0, nwr = 0, n_abort = 0;
   int   m_addr = 0, m_frame = 0, m_ent = 0, m_last = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_start(input int ent, input int nf);
      m_addr  = 0;
      m_frame = 0;
      m_ent   = ent;
      m_last  = (nf > 4) ? 4 : nf;
   endtask

   // Monitor: retire writes first, then record the handshake due at the next edge.
   always @(negedge clk_i) begin
      exp_t e;
      if (wen_o) begin
         nwr++;
         chk("wen_expected", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("memory_selector", 32'(memory_selector_o), e.sel);
            chk("waddr", 32'(waddr_o), e.addr);
            chk("wdata", 32'(wdata_o), e.data);
            chk("wr_mem_updated", 32'(mem_updated_o), 32'(e.fin));
         end
      end else begin
         chk("missing_write", q.size(), 0);
      end
      if (abort_o) n_abort++;
      if (s_valid_i && s_ready_o) begin
         e.sel  = m_frame;
         e.addr = m_addr;
         e.data = int'(s_data_i);
         e.fin  = (m_addr == m_ent - 1) && (m_frame == m_last);
         q.push_back(e);
         nacc++;
         if (m_addr == m_ent - 1) begin
            m_addr = 0;
            m_frame++;
         end else begin
            m_addr++;
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic sample();
      @(negedge clk_i);
      #1;
   endtask

   // Stream entries until the model has seen target_acc accepts, then idle the source.
   task automatic run_until(input int target_acc, input bit rand_valid);
      int cyc = 0;
      forever begin
         tick();
         if (nacc >= target_acc) break;
         if (cyc >= 300) begin
            chk("accept_timeout", nacc, target_acc);
            break;
         end
         s_data_i  = 17'($urandom);
         s_valid_i = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
         cyc++;
      end
      s_valid_i = 1'b0;
      sample();
   endtask

   task automatic chk_reset_outputs();
      chk("rst_s_ready", 32'(s_ready_o), 0);
      chk("rst_wen", 32'(wen_o), 0);
      chk("rst_waddr", 32'(waddr_o), 0);
      chk("rst_wdata", 32'(wdata_o), 0);
      chk("rst_sel", 32'(memory_selector_o), 0);
      chk("rst_mem_updated", 32'(mem_updated_o), 0);
      chk("rst_abort", 32'(abort_o), 0);
   endtask

   initial begin
      nrst_i = 1'b1; enable_i = 1'b0; s_valid_i = 1'b0; s_data_i = 17'd0;
      update_mem_i = 1'b0; entries_per_frame_i = 11'd3; number_of_frames_i = 3'd1;
      #2 nrst_i = 1'b0;
      repeat (2) sample();
      chk_reset_outputs();
      tick(); nrst_i = 1'b1;

      // 3 entries x 2 frames with a continuously valid source
      tick(); enable_i = 1'b1; s_valid_i = 1'b1; s_data_i = 17'h1abcd; model_start(3, 1);
      run_until(6, 1'b0);
      chk("t1_nwr", nwr, 6);
      chk("t1_mem_updated", 32'(mem_updated_o), 1);
      chk("t1_ready_done", 32'(s_ready_o), 0);
      s_valid_i = 1'b1;
      repeat (3) tick();
      sample();
      chk("t1_done_no_writes", nwr, 6);
      chk("t1_done_ready", 32'(s_ready_o), 0);
      chk("t1_done_mem_updated", 32'(mem_updated_o), 1);

      // bank toggle while DONE reloads from sel0 addr0
      tick(); update_mem_i = 1'b1; model_start(3, 1);
      tick(); sample();
      chk("t2_mem_cleared", 32'(mem_updated_o), 0);
      run_until(12, 1'b0);
      chk("t2_nwr", nwr, 12);
      chk("t2_mem_updated", 32'(mem_updated_o), 1);

      // toggle after 4 of 6 writes aborts and restarts; config change mid-load ignored
      tick(); update_mem_i = 1'b0; s_valid_i = 1'b1; model_start(3, 1);
      run_until(16, 1'b0);
      chk("t3_partial_nwr", nwr, 16);
      tick(); update_mem_i = 1'b1; s_valid_i = 1'b1; model_start(3, 1);
      sample();
      chk("t3_ready_on_toggle", 32'(s_ready_o), 0);
      chk("t3_abort_early", 32'(abort_o), 0);
      tick(); entries_per_frame_i = 11'd7; number_of_frames_i = 3'd4;
      sample();
      chk("t3_abort_pulse", 32'(abort_o), 1);
      tick(); sample();
      chk("t3_abort_clear", 32'(abort_o), 0);
      run_until(22, 1'b0);
      chk("t3_nwr", nwr, 22);
      chk("t3_mem_updated", 32'(mem_updated_o), 1);

      // empty table: LOAD -> DONE in one cycle, no writes
      tick(); enable_i = 1'b0; entries_per_frame_i = 11'd0; number_of_frames_i = 3'd1;
      s_valid_i = 1'b1;
      tick(); sample();
      chk("t4_idle_mem", 32'(mem_updated_o), 0);
      chk("t4_idle_ready", 32'(s_ready_o), 0);
      tick(); enable_i = 1'b1; model_start(0, 1);
      tick(); sample();
      chk("t4_load_mem", 32'(mem_updated_o), 0);
      chk("t4_load_ready", 32'(s_ready_o), 0);
      tick(); sample();
      chk("t4_done_mem", 32'(mem_updated_o), 1);
      chk("t4_nwr", nwr, 22);

      // frame count clamps to 4 (10 writes), random source valid
      tick(); enable_i = 1'b0; s_valid_i = 1'b0;
      entries_per_frame_i = 11'd2; number_of_frames_i = 3'd7;
      tick();
      tick(); enable_i = 1'b1; model_start(2, 7);
      run_until(32, 1'b1);
      chk("t5_nwr", nwr, 32);
      chk("t5_mem_updated", 32'(mem_updated_o), 1);
      s_valid_i = 1'b1;
      repeat (3) tick();
      sample();
      chk("t5_no_extra_writes", nwr, 32);

      // disable mid-load, then re-enable restarts at sel0 addr0
      tick(); update_mem_i = 1'b0; model_start(2, 7);
      run_until(35, 1'b0);
      tick(); enable_i = 1'b0;
      tick(); s_valid_i = 1'b1;
      sample();
      chk("t6_idle_ready", 32'(s_ready_o), 0);
      chk("t6_idle_mem", 32'(mem_updated_o), 0);
      repeat (2) tick();
      sample();
      chk("t6_idle_no_writes", nwr, 35);
      tick(); enable_i = 1'b1; model_start(2, 7);
      run_until(45, 1'b0);
      chk("t6_nwr", nwr, 45);
      chk("t6_mem_updated", 32'(mem_updated_o), 1);

      // reset mid-load discards progress; no spurious toggle after release
      tick(); update_mem_i = 1'b1; s_valid_i = 1'b1; model_start(2, 7);
      run_until(48, 1'b0);
      tick(); nrst_i = 1'b0;
      sample();
      chk_reset_outputs();
      tick(); nrst_i = 1'b1; s_valid_i = 1'b1; model_start(2, 7);
      run_until(58, 1'b0);
      chk("t7_nwr", nwr, 58);
      chk("t7_mem_updated", 32'(mem_updated_o), 1);
      chk("abort_pulse_count", n_abort, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
